ex_mul_div_unit: RTL and testbench
==================================

// Module: ex_mul_div_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX barrier outputs.
//  Sits beside the single-cycle ALU. Takes a multiply or divide op and computes it over several cycles.
//  While an op is in flight it drives mulDivStall, which freezes PC, IF/ID and ID/EX.
//  Returns one 32-bit result with a single-cycle mulDivDone pulse.
// PARAMETERS
//  WIDTH  32  operand/result width; also the number of iteration cycles for mul and div
// PORTS
//  clk                 in   1      clock; all state updates on posedge
//  rst                 in   1      synchronous, active-low reset (rst==0 on a posedge resets)
//  exMulDivStart       in   1      ID/EX holds an M-ext op (funct7==0000001, R-type); held high while stalled
//  exFunct3            in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  exLHSRegisterValue  in   WIDTH  rs1 operand (post-forwarding)
//  exRHSRegisterValue  in   WIDTH  rs2 operand (post-forwarding)
//  exFlush             in   1      branch/jump kill of the EX-stage op
//  mulDivResult        out  WIDTH  result; valid only while mulDivDone==1
//  mulDivDone          out  1      registered; high exactly one cycle (state DONE)
//  mulDivBusy          out  1      registered; high in states MUL or DIV
//  mulDivStall         out  1      combinational: exMulDivStart & ~mulDivDone & ~exFlush
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, counter=0, mulDivResult=0, mulDivDone=0, mulDivBusy=0.
//    Internal accumulators are cleared. Reset wins over every other input and aborts an in-flight op.
//  States: IDLE, MUL, DIV, DONE.
//  IDLE, exMulDivStart=1 and exFlush=0 at cycle T:
//    - Latch funct3. Latch the absolute values of the signed operands and the sign-fix flags.
//    - Signed operands: MUL/MULH both; MULHSU rs1 only; DIV/REM both. MULHU/DIVU/REMU unsigned.
//    - funct3[2]==0 -> MUL; funct3[2]==1 -> DIV.
//    - Exception: divide special cases go straight to DONE (next list).
//  Divide special cases (detected in IDLE, result in DONE at T+1):
//    - Divisor==0: DIV/DIVU quotient=all ones; REM/REMU remainder=rs1.
//    - DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF: quotient=0x80000000, remainder=0.
//  MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product.
//    Runs WIDTH cycles (counter 0..WIDTH-1), then goes to DONE.
//  DIV: restoring division, one quotient bit per cycle.
//    Runs WIDTH cycles, then goes to DONE.
//  Entering DONE, select and register the result:
//    - MUL: low WIDTH bits of the signed-corrected product.
//    - MULH*: high WIDTH bits of the product.
//    - Product negated (two's complement, 2*WIDTH bits) if the operand signs differ.
//    - Quotient negated if the operand signs differ.
//    - Remainder takes the sign of the dividend.
//  Latency: normal ops mulDivDone at T+WIDTH+1; special cases at T+1.
//  mulDivStall is high from T through the cycle before DONE, and low in DONE.
//  DONE -> IDLE unconditionally. The pipeline advances on the DONE edge.
//    A start seen in IDLE afterwards is a new instruction.
//  exFlush=1 in any state: next state IDLE, busy=0.
//    No mulDivDone is produced for the killed op, and mulDivResult is unchanged.
//    A start in IDLE is ignored while exFlush=1.
//  exMulDivStart dropping mid-op without exFlush is illegal. The unit ignores it and completes the op.
//  Operand inputs are sampled only in IDLE; later changes have no effect.
// TESTING
//  MUL 7 x 0xFFFFFFFD (-3) -> mulDivDone at T+33, result 0xFFFFFFEB; stall high T..T+32.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
//  REM -7 % 2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; all done at T+33.
//  DIVU 5/0 -> 0xFFFFFFFF and REM 7/0 -> 7, done at T+1.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1.
//  exFlush at T+10 -> IDLE at T+11, no done pulse.
//  A new start at T+12 completes normally at T+45.
//  rst=0 at T+5 mid-DIV -> all outputs 0 next cycle; back-to-back starts yield one done per op.

Source files
------------

// File: rtl/ex_mul_div_unit.sv
// Purpose : iterative RV32M multiply/divide beside the EX-stage ALU (shift-add mul, restoring div).
// Latency : mulDivDone WIDTH+1 cycles after the accepting IDLE cycle; divide-by-zero/overflow in 1 cycle.
// Backpr. : mulDivStall freezes PC, IF/ID and ID/EX while an op is pending; exFlush kills it silently.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   exMulDivStart       M-extension op present in ID/EX (held while stalled)
//   exFunct3            MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU select
//   exLHSRegisterValue  rs1 operand, exRHSRegisterValue rs2 operand (sampled in IDLE only)
//   exFlush             kills the EX-stage op
//   mulDivResult        result, valid while mulDivDone
//   mulDivDone          one-cycle completion pulse
//   mulDivBusy          iterating (MUL or DIV state)
//   mulDivStall         combinational pipeline freeze request
module ex_mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exMulDivStart,
   input  logic [2:0]       exFunct3,
   input  logic [WIDTH-1:0] exLHSRegisterValue,
   input  logic [WIDTH-1:0] exRHSRegisterValue,
   input  logic             exFlush,
   output logic [WIDTH-1:0] mulDivResult,
   output logic             mulDivDone,
   output logic             mulDivBusy,
   output logic             mulDivStall
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DIV  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state;
   logic [CW-1:0]    counter;
   logic [2:0]       funct3Q;
   logic             negRes;     // product / quotient must be negated
   logic             negRem;     // remainder takes the dividend's sign
   // Shared datapath: MUL keeps {partial product, multiplier} in {accHi, accLo};
   // DIV keeps {partial remainder, dividend/quotient} in {accHi, accLo}.
   logic [WIDTH-1:0] accHi;
   logic [WIDTH-1:0] accLo;
   logic [WIDTH-1:0] opB;        // multiplicand or divisor magnitude

   // Operand decode, only meaningful in IDLE
   logic             lhsSigned, rhsSigned, lhsNeg, rhsNeg, isDiv, divByZero, divOvf;
   logic [WIDTH-1:0] lhsAbs, rhsAbs, specialResult;

   always_comb begin
      lhsSigned = (exFunct3 != 3'b011) && (exFunct3 != 3'b101) && (exFunct3 != 3'b111);
      rhsSigned = (exFunct3 == 3'b000) || (exFunct3 == 3'b001) ||
                  (exFunct3 == 3'b100) || (exFunct3 == 3'b110);
      lhsNeg    = lhsSigned & exLHSRegisterValue[WIDTH-1];
      rhsNeg    = rhsSigned & exRHSRegisterValue[WIDTH-1];
      lhsAbs    = lhsNeg ? -exLHSRegisterValue : exLHSRegisterValue;
      rhsAbs    = rhsNeg ? -exRHSRegisterValue : exRHSRegisterValue;
      isDiv     = exFunct3[2];
      divByZero = isDiv && (exRHSRegisterValue == '0);
      // Signed most-negative / -1 overflows the iterative path; answer directly.
      divOvf    = isDiv && !exFunct3[0] &&
                  (exLHSRegisterValue == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (exRHSRegisterValue == '1);
      if (divByZero)
         specialResult = exFunct3[1] ? exLHSRegisterValue : '1;
      else
         specialResult = exFunct3[1] ? '0 : exLHSRegisterValue;
   end

   // One iteration step for the current op, plus the result it would produce
   logic [WIDTH:0]     mulSum, divShift;
   logic [WIDTH-1:0]   nextHi, nextLo, quotFix, remFix, finalResult;
   logic [2*WIDTH-1:0] product, prodFix;

   always_comb begin
      mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
      divShift = {accHi, accLo[WIDTH-1]};
      if (funct3Q[2]) begin
         if (divShift >= {1'b0, opB}) begin
            nextHi = divShift[WIDTH-1:0] - opB;   // difference < divisor, fits WIDTH bits
            nextLo = {accLo[WIDTH-2:0], 1'b1};
         end else begin
            nextHi = divShift[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], 1'b0};
         end
      end else begin
         nextHi = mulSum[WIDTH:1];
         nextLo = {mulSum[0], accLo[WIDTH-1:1]};
      end
      product  = {nextHi, nextLo};
      prodFix  = negRes ? -product : product;
      quotFix  = negRes ? -nextLo : nextLo;
      remFix   = negRem ? -nextHi : nextHi;
      if (funct3Q[2])
         finalResult = funct3Q[1] ? remFix : quotFix;
      else if (funct3Q[1:0] == 2'b00)
         finalResult = prodFix[WIDTH-1:0];
      else
         finalResult = prodFix[2*WIDTH-1:WIDTH];
   end

   assign mulDivStall = exMulDivStart & ~mulDivDone & ~exFlush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         counter      <= '0;
         funct3Q      <= '0;
         negRes       <= 1'b0;
         negRem       <= 1'b0;
         accHi        <= '0;
         accLo        <= '0;
         opB          <= '0;
         mulDivResult <= '0;
         mulDivDone   <= 1'b0;
         mulDivBusy   <= 1'b0;
      end else begin
         mulDivDone <= 1'b0;
         if (exFlush) begin
            state      <= IDLE;
            mulDivBusy <= 1'b0;
            counter    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (exMulDivStart) begin
                     funct3Q <= exFunct3;
                     negRes  <= lhsNeg ^ rhsNeg;
                     negRem  <= lhsNeg;
                     counter <= '0;
                     accHi   <= '0;
                     if (divByZero || divOvf) begin
                        state        <= DONE;
                        mulDivDone   <= 1'b1;
                        mulDivResult <= specialResult;
                     end else if (isDiv) begin
                        state      <= DIV;
                        mulDivBusy <= 1'b1;
                        accLo      <= lhsAbs;
                        opB        <= rhsAbs;
                     end else begin
                        state      <= MUL;
                        mulDivBusy <= 1'b1;
                        accLo      <= rhsAbs;
                        opB        <= lhsAbs;
                     end
                  end
               end
               MUL, DIV: begin
                  accHi   <= nextHi;
                  accLo   <= nextLo;
                  counter <= counter + CW'(1);
                  if (counter == CW'(WIDTH-1)) begin
                     state        <= DONE;
                     counter      <= '0;
                     mulDivBusy   <= 1'b0;
                     mulDivDone   <= 1'b1;
                     mulDivResult <= finalResult;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Self-checking bench for ex_mul_div_unit: directed RV32M vectors with literal results,
// flush/reset/drop-start scenarios and randomized back-to-back ops against a 64-bit
// arithmetic reference and a cycle-count timing model.
module tb_ex_mul_div_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          exMulDivStart;
   logic [2:0]    exFunct3;
   logic [W-1:0]  exLHSRegisterValue;
   logic [W-1:0]  exRHSRegisterValue;
   logic          exFlush;
   logic [W-1:0]  mulDivResult;
   logic          mulDivDone;
   logic          mulDivBusy;
   logic          mulDivStall;

   ex_mul_div_unit #(.WIDTH(W)) dut (
      .clk                (clk),
      .rst                (rst),
      .exMulDivStart      (exMulDivStart),
      .exFunct3           (exFunct3),
      .exLHSRegisterValue (exLHSRegisterValue),
      .exRHSRegisterValue (exRHSRegisterValue),
      .exFlush            (exFlush),
      .mulDivResult       (mulDivResult),
      .mulDivDone         (mulDivDone),
      .mulDivBusy         (mulDivBusy),
      .mulDivStall        (mulDivStall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nChecks = 0;
   int nFails  = 0;
   bit chkEn   = 1'b0;

   // Model of the op in flight
   bit           mActive  = 1'b0;
   bit           mSpecial = 1'b0;
   int           mT       = 0;
   int           mDoneCyc = 0;
   logic [W-1:0] mExp     = '0;
   logic [W-1:0] mLastResult = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] refResult(input logic [2:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0]        ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      p  = '0;
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return '1; return a / b; end
         3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; return a % b; end
      endcase
   endfunction

   function automatic bit isSpecial(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Per-cycle compare against the timing model
   always @(negedge clk) begin : cmp
      bit eDone, eBusy, eStall;
      if (chkEn) begin
         eDone  = mActive && (cyc == mDoneCyc);
         eBusy  = mActive && !mSpecial && (cyc > mT) && (cyc <= mT + W);
         eStall = exMulDivStart && !eDone && !exFlush;
         check("done",  {31'b0, mulDivDone},  {31'b0, eDone});
         check("busy",  {31'b0, mulDivBusy},  {31'b0, eBusy});
         check("stall", {31'b0, mulDivStall}, {31'b0, eStall});
         if (eDone) check("result", mulDivResult, mExp);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      exMulDivStart      = 1'b1;
      exFunct3           = f;
      exLHSRegisterValue = a;
      exRHSRegisterValue = b;
      mActive  = 1'b1;
      mT       = cyc;
      mSpecial = isSpecial(f, a, b);
      mDoneCyc = cyc + (mSpecial ? 1 : W + 1);
      mExp     = refResult(f, a, b);
   endtask

   // Issue an op, scramble operands while it runs, finish one cycle after done
   task automatic runOp(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit useLit, input logic [W-1:0] lit, input int dropAt);
      issue(f, a, b);
      while (cyc < mDoneCyc) begin
         tick();
         if (cyc < mDoneCyc) begin
            exLHSRegisterValue = $urandom;
            exRHSRegisterValue = $urandom;
            exFunct3           = 3'($urandom_range(0, 7));
         end
         if (dropAt > 0 && cyc == mT + dropAt) exMulDivStart = 1'b0;
      end
      if (useLit) check("literal", mulDivResult, lit);
      mLastResult = mExp;
      tick();
      exMulDivStart = 1'b0;
      mActive       = 1'b0;
   endtask

   function automatic logic [W-1:0] pickOperand();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      exMulDivStart = 1'b0;
      exFunct3 = 3'd0;
      exLHSRegisterValue = '0;
      exRHSRegisterValue = '0;
      exFlush = 1'b0;
      tick();
      tick();
      check("rstDone",   {31'b0, mulDivDone}, 32'd0);
      check("rstBusy",   {31'b0, mulDivBusy}, 32'd0);
      check("rstResult", mulDivResult,        32'd0);
      rst   = 1'b1;
      chkEn = 1'b1;
      tick();

      // Directed vectors, issued back-to-back
      runOp(3'd0, 32'd7,         32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0);
      runOp(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 0);
      runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0);
      runOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0);
      runOp(3'd4, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFD, 0);
      runOp(3'd6, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 0);
      runOp(3'd5, 32'd100,       32'd7,         1, 32'd14,        0);
      runOp(3'd7, 32'd100,       32'd7,         1, 32'd2,         0);
      runOp(3'd5, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 0);
      runOp(3'd6, 32'd7,         32'd0,         1, 32'd7,         0);
      runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
      runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         0);

      // Start dropped mid-op: the op still completes
      runOp(3'd0, 32'd3, 32'd5, 1, 32'd15, 3);

      // Flush at T+10, idle at T+11, new start at T+12
      tick();
      issue(3'd5, 32'd1000, 32'd3);
      repeat (10) tick();
      exFlush = 1'b1;
      tick();
      exFlush       = 1'b0;
      exMulDivStart = 1'b0;
      mActive       = 1'b0;
      check("flushResultHeld", mulDivResult, mLastResult);
      tick();
      runOp(3'd0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0);

      // Start while flushing in IDLE is ignored
      exMulDivStart = 1'b1;
      exFlush       = 1'b1;
      tick();
      exMulDivStart = 1'b0;
      exFlush       = 1'b0;
      repeat (3) tick();

      // Reset mid-divide
      issue(3'd4, 32'd12345, 32'd67);
      repeat (5) tick();
      rst = 1'b0;
      tick();
      rst           = 1'b1;
      exMulDivStart = 1'b0;
      mActive       = 1'b0;
      mLastResult   = '0;
      check("midRstDone",   {31'b0, mulDivDone}, 32'd0);
      check("midRstBusy",   {31'b0, mulDivBusy}, 32'd0);
      check("midRstResult", mulDivResult,        32'd0);
      tick();

      // Randomized ops with occasional gaps
      for (int i = 0; i < 80; i++) begin
         logic [2:0]   f;
         logic [W-1:0] a, b;
         f = 3'($urandom_range(0, 7));
         a = pickOperand();
         b = pickOperand();
         repeat ($urandom_range(0, 2)) tick();
         runOp(f, a, b, 0, '0, 0);
      end

      repeat (3) tick();
      chkEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
